// File: rtl/pc_fetch_unit_if.sv
// Program-counter fetch bus: decoder controls in, ROM address and fetch status out.
// Optional branch_cnt signal is present only when PC_BRANCH_CNT_EN is defined.
interface pc_fetch_unit_if #(
  parameter int PSIZE = 6,
  parameter int OSIZE = 6
);
  logic             en;
  logic             PCincr;
  logic             PCrelbranch;
  logic [OSIZE-1:0] Branchoffset;
  logic [PSIZE-1:0] PCout;
  logic             fetch_valid;
  logic             halted;
`ifdef PC_BRANCH_CNT_EN
  logic [15:0]      branch_cnt;

  modport master (
    output en, PCincr, PCrelbranch, Branchoffset,
    input  PCout, fetch_valid, halted, branch_cnt
  );
  modport slave (
    input  en, PCincr, PCrelbranch, Branchoffset,
    output PCout, fetch_valid, halted, branch_cnt
  );
`else
  modport master (
    output en, PCincr, PCrelbranch, Branchoffset,
    input  PCout, fetch_valid, halted
  );
  modport slave (
    input  en, PCincr, PCrelbranch, Branchoffset,
    output PCout, fetch_valid, halted
  );
`endif
endinterface

// File: rtl/pc_fetch_unit.sv
// PC stage with stall, post-reset fetch-valid sequencing and self-loop halt.
// Define PC_BRANCH_CNT_EN to add the saturating taken-branch counter (branch_cnt).
module pc_fetch_unit #(
  parameter int PSIZE    = 6,
  parameter int OSIZE    = 6,
  parameter int RST_ADDR = 0
) (
  input  logic            clk,
  input  logic            nreset,
  pc_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    RESET_WAIT,
    RUN,
    HALT
  } state_t;

  localparam logic [PSIZE-1:0] RST_PC = PSIZE'(RST_ADDR);

  state_t           state, state_next;
  logic [PSIZE-1:0] pc, pc_next;
  logic [PSIZE-1:0] offset_ext;
  logic             take_branch;

  // Wider offsets are truncated; narrower ones are sign-extended to the PC width.
  generate
    if (OSIZE >= PSIZE) begin : g_off_trunc
      assign offset_ext = bus.Branchoffset[PSIZE-1:0];
    end else begin : g_off_sext
      assign offset_ext = {{(PSIZE-OSIZE){bus.Branchoffset[OSIZE-1]}}, bus.Branchoffset};
    end
  endgenerate

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    take_branch = 1'b0;
    unique case (state)
      RESET_WAIT: state_next = RUN;
      RUN: begin
        if (bus.en) begin
          if (bus.PCrelbranch) begin
            take_branch = 1'b1;
            pc_next     = pc + offset_ext;
            if (bus.Branchoffset == '0) state_next = HALT;
          end else if (bus.PCincr) begin
            pc_next = pc + PSIZE'(1);
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = RESET_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= RESET_WAIT;
      pc    <= RST_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  assign bus.PCout       = pc;
  assign bus.fetch_valid = (state == RUN);
  assign bus.halted      = (state == HALT);

`ifdef PC_BRANCH_CNT_EN
  logic [15:0] branch_cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      branch_cnt_q <= '0;
    end else if (take_branch && branch_cnt_q != '1) begin
      branch_cnt_q <= branch_cnt_q + 16'd1;
    end
  end

  assign bus.branch_cnt = branch_cnt_q;
`endif

  a_ctrl_known: assert property (
    @(posedge clk) disable iff (!nreset)
    bus.fetch_valid |-> !$isunknown({bus.PCincr, bus.PCrelbranch})
  ) else $error("PCincr/PCrelbranch unknown while fetch_valid is high");

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand sequences, random run vs model.
module tb_pc_fetch_unit;
  localparam int PSIZE = 6;
  localparam int OSIZE = 6;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.PSIZE(PSIZE), .OSIZE(OSIZE)) bus();

  pc_fetch_unit #(.PSIZE(PSIZE), .OSIZE(OSIZE), .RST_ADDR(0)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         rst_n;
    bit         en;
    bit         incr;
    bit         rel;
    logic [5:0] off;
    int         pc;
    bit         fv;
    bit         h;
  } vec_t;

  // reference model state
  int m_pc;
  bit m_started;
  bit m_halted;
  int m_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int pc, input bit fv, input bit h);
    check({tag, ".pc"}, int'(bus.PCout), pc);
    check({tag, ".fetch_valid"}, int'(bus.fetch_valid), int'(fv));
    check({tag, ".halted"}, int'(bus.halted), int'(h));
  endtask

  task automatic drive(input bit r, input bit e, input bit i, input bit b, input logic [5:0] o);
    @(negedge clk);
    nreset = r;
    bus.en = e;
    bus.PCincr = i;
    bus.PCrelbranch = b;
    bus.Branchoffset = o;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_pc = 0;
    m_started = 1'b0;
    m_halted = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(input bit e, input bit i, input bit b, input logic [5:0] o);
    int so;
    if (m_halted) return;
    if (!m_started) begin
      m_started = 1'b1;
      return;
    end
    if (!e) return;
    if (b) begin
      so = int'($signed(o));
      if (m_cnt < 65535) m_cnt++;
      if (so == 0) m_halted = 1'b1;
      else m_pc = (((m_pc + so) % 64) + 64) % 64;
    end else if (i) begin
      m_pc = (m_pc + 1) % 64;
    end
  endfunction

  vec_t vecs[25];

  initial begin
    bus.en = 1'b0;
    bus.PCincr = 1'b0;
    bus.PCrelbranch = 1'b0;
    bus.Branchoffset = '0;

    vecs = '{
      '{1'b0, 1'b1, 1'b1, 1'b0, 6'h00,  0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 6'h00,  0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 6'h00,  1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 6'h00,  2, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 6'h00,  3, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h07, 10, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 6'h3C,  6, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h04, 10, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h3C,  6, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h39, 63, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 6'h00,  0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h02,  2, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h3B, 61, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h20, 29, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h28,  5, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00,  5, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 6'h03,  5, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00,  5, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 6'h00,  6, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 6'h00,  6, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h0E, 20, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h00, 20, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 20, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 6'h05, 20, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 20, 1'b0, 1'b1}
    };

    repeat (2) @(posedge clk);

    for (int k = 0; k < 25; k++) begin
      drive(vecs[k].rst_n, vecs[k].en, vecs[k].incr, vecs[k].rel, vecs[k].off);
      check_out($sformatf("vec[%0d]", k), vecs[k].pc, vecs[k].fv, vecs[k].h);
    end

    // asynchronous reset pulled mid-cycle while halted
    @(negedge clk);
    #2 nreset = 1'b0;
    #1 check_out("async_rst", 0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h05);
    check_out("rst_hold", 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 6'h05);
    check_out("reset_wait_ignores", 0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 6'h05);
    check_out("first_branch", 5, 1'b1, 1'b0);

`ifdef PC_BRANCH_CNT_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
    check("cnt_reset", int'(bus.branch_cnt), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 6'h00);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 6'h3F);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6'h00);
    check("cnt_loop7", int'(bus.branch_cnt), 7);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 6'h02);
    check("cnt_stall", int'(bus.branch_cnt), 7);
    @(negedge clk);
    force dut.branch_cnt_q = 16'hFFFF;
    #1 release dut.branch_cnt_q;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6'h01);
    check("cnt_saturate", int'(bus.branch_cnt), 65535);
`endif

    // randomized run against the reference model
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
    model_reset();
    for (int k = 0; k < 3000; k++) begin
      bit e, i, b;
      logic [5:0] o;
      @(negedge clk);
      if ($urandom_range(99) == 0) begin
        nreset = 1'b0;
        model_reset();
        #1 check_out($sformatf("rnd_rst[%0d]", k), m_pc, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        continue;
      end
      e = ($urandom_range(7) != 0);
      i = $urandom_range(1) == 1;
      b = ($urandom_range(3) == 0);
      o = ($urandom_range(39) == 0) ? 6'h00 : 6'($urandom);
      nreset = 1'b1;
      bus.en = e;
      bus.PCincr = i;
      bus.PCrelbranch = b;
      bus.Branchoffset = o;
      @(posedge clk);
      model_step(e, i, b, o);
      #1;
      check_out($sformatf("rnd[%0d]", k), m_pc, m_started && !m_halted, m_halted);
`ifdef PC_BRANCH_CNT_EN
      check($sformatf("rnd_cnt[%0d]", k), int'(bus.branch_cnt), m_cnt);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
